decoder_scan: RTL and testbench

Parametrised registered N-to-2^N one-hot decoder with enable and an optional autonomous scan mode. In scan mode it sweeps a walking one-hot across all outputs with programmable dwell and direction, so it can drive row strobes or digit selects. It succeeds the fixed 3-to-8 enabled decoders and sits between control logic and strobed loads: row drivers, multiplexed displays, chip selects.

---
 rtl/decoder_pkg.sv | 23 ++
 rtl/decoder_scan_if.sv | 27 ++
 rtl/decoder_onehot.sv | 22 ++
 rtl/decoder_scan.sv | 142 ++++++++++++++
 tb/tb_decoder_scan.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the decoder_scan block: FSM state encoding,
// output-width constants and a generic one-hot helper.
package decoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int MAX_N     = 8;
    localparam int MAX_W     = 1 << MAX_N;
    localparam int DEF_N     = 3;
    localparam int DEF_OUT_W = 1 << DEF_N;

    // Full-width one-hot; callers keep the low 2^N bits they need.
    function automatic logic [MAX_W-1:0] onehot(input logic [MAX_N-1:0] sel);
        logic [MAX_W-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/decoder_scan_if.sv
// Handshake/bus bundle for decoder_scan: control inputs toward the decoder,
// strobe outputs and scan status back toward the controller.
interface decoder_scan_if
    import decoder_pkg::*;
#(
    parameter int N = DEF_N
);
    logic               en;
    logic               mode;
    logic [N-1:0]       sel;
    logic               start;
    logic               dir;
    logic [(1<<N)-1:0]  y;
    logic [N-1:0]       idx;
    logic               busy;
    logic               done;

    modport master (
        output en, mode, sel, start, dir,
        input  y, idx, busy, done
    );

    modport slave (
        input  en, mode, sel, start, dir,
        output y, idx, busy, done
    );
endinterface

// File: rtl/decoder_onehot.sv
// Combinational N-to-2^N one-hot decode with enable; feeds the y register
// of decoder_scan.
module decoder_onehot
    import decoder_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0]      sel,
    input  logic              en,
    output logic [(1<<N)-1:0] y
);
    localparam int OUT_W = 1 << N;

    logic [MAX_W-1:0] full_w;
    logic             unused_hi;

    assign full_w = onehot(MAX_N'(sel));
    // Bits above 2^N are always zero for a legal sel; consumed to keep lint quiet.
    assign unused_hi = |full_w;
    assign y = en ? full_w[OUT_W-1:0] : '0;

endmodule

// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with enable. Defining DECODER_SCAN_EN
// adds an autonomous walking-one scan with programmable dwell and direction.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int DWELL = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    decoder_scan_if.slave bus
);
    localparam int OUT_W = 1 << N;

    logic [N-1:0]     dec_sel;
    logic             dec_en;
    logic [OUT_W-1:0] dec_y;
    logic [OUT_W-1:0] y_q;
    logic [N-1:0]     idx_q;
    logic [N-1:0]     idx_d;

    decoder_onehot #(.N(N)) u_onehot (
        .sel (dec_sel),
        .en  (dec_en),
        .y   (dec_y)
    );

    // Output register stage: y and idx are driven straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= '0;
            idx_q <= '0;
        end else begin
            y_q   <= dec_y;
            idx_q <= idx_d;
        end
    end

    assign bus.y   = y_q;
    assign bus.idx = idx_q;

`ifdef DECODER_SCAN_EN
    localparam int             CW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]  DWELL_LAST = CW'(DWELL - 1);
    localparam logic [N-1:0]   STEP_LAST  = '1;

    state_t        state_q, state_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dir_q, dir_d;
    logic [CW-1:0] dwell_q, dwell_d;
    logic [N-1:0]  step_q, step_d;
    logic [N-1:0]  idx_step;

    // Modulo-2^N step falls out of the N-bit wrap.
    assign idx_step = dir_q ? (idx_q - N'(1)) : (idx_q + N'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dir_q   <= 1'b0;
            dwell_q <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dir_q   <= dir_d;
            dwell_q <= dwell_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dir_d   = dir_q;
        dwell_d = dwell_q;
        step_d  = step_q;
        idx_d   = idx_q;
        dec_sel = idx_q;
        dec_en  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!bus.mode) begin
                    dec_sel = bus.sel;
                    dec_en  = bus.en;
                    idx_d   = bus.sel;
                end else if (bus.start && bus.en) begin
                    state_d = SCAN;
                    busy_d  = 1'b1;
                    dir_d   = bus.dir;
                    dwell_d = '0;
                    step_d  = '0;
                    idx_d   = bus.sel;
                    dec_sel = bus.sel;
                    dec_en  = 1'b1;
                end
            end
            SCAN: begin
                if (!bus.en) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (dwell_q != DWELL_LAST) begin
                    dwell_d = dwell_q + CW'(1);
                    dec_en  = 1'b1;
                end else if (step_q == STEP_LAST) begin
                    // Last dwell of the last index: sweep complete.
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    dwell_d = '0;
                    step_d  = step_q + N'(1);
                    idx_d   = idx_step;
                    dec_sel = idx_step;
                    dec_en  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
`else
    localparam int unused_dwell = DWELL;
    logic          unused_ctl;

    assign dec_sel    = bus.sel;
    assign dec_en     = bus.en;
    assign idx_d      = bus.sel;
    assign unused_ctl = &{1'b0, bus.mode, bus.start, bus.dir};
    assign bus.busy   = 1'b0;
    assign bus.done   = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_scan.sv
// Directed, table-driven bench for decoder_scan (N = 3); scan scenarios are
// exercised when DECODER_SCAN_EN is defined, pure-decoder behaviour otherwise.
module tb_decoder_scan;
    import decoder_pkg::*;

    localparam int N = 3;
`ifdef DECODER_SCAN_EN
    localparam int DW = 2;
`else
    localparam int DW = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    decoder_scan_if #(.N(N)) bus ();

    decoder_scan #(.N(N), .DWELL(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       en;
        logic [2:0] sel;
        logic [7:0] exp_y;
        logic [2:0] exp_idx;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef DECODER_SCAN_EN
    // Launch a scan and check every cycle of it; inj >= 0 fires a stray start
    // (plus mode/sel/dir noise) at that scan cycle, which must change nothing.
    task automatic run_scan(input logic [2:0] s, input logic d, input int inj, input string tag);
        int e;
        bus.mode  = 1'b1;
        bus.sel   = s;
        bus.dir   = d;
        bus.en    = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 8 * DW; k++) begin
            e = d ? ((int'(s) - k / DW) & 7) : ((int'(s) + k / DW) & 7);
            check({tag, "_y"},    32'(bus.y),    32'(1 << e));
            check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            check({tag, "_done"}, 32'(bus.done), 32'd0);
            if (k == inj) begin
                bus.start = 1'b1;
                bus.sel   = ~s;
                bus.dir   = ~d;
                bus.mode  = 1'b0;
            end else if (k == inj + 1) begin
                bus.start = 1'b0;
                bus.sel   = s;
                bus.dir   = d;
                bus.mode  = 1'b1;
            end
            tick();
        end
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd1);
        check({tag, "_busy_fall"},  32'(bus.busy), 32'd0);
        check({tag, "_y_end"},      32'(bus.y),    32'd0);
    endtask
`endif

    initial begin
        vecs[0] = '{1'b1, 3'd0, 8'h01, 3'd0};
        vecs[1] = '{1'b1, 3'd1, 8'h02, 3'd1};
        vecs[2] = '{1'b1, 3'd2, 8'h04, 3'd2};
        vecs[3] = '{1'b1, 3'd3, 8'h08, 3'd3};
        vecs[4] = '{1'b1, 3'd4, 8'h10, 3'd4};
        vecs[5] = '{1'b1, 3'd5, 8'h20, 3'd5};
        vecs[6] = '{1'b1, 3'd6, 8'h40, 3'd6};
        vecs[7] = '{1'b1, 3'd7, 8'h80, 3'd7};
        vecs[8] = '{1'b0, 3'd5, 8'h00, 3'd5};
        vecs[9] = '{1'b1, 3'd2, 8'h04, 3'd2};

        rst_n     = 1'b0;
        bus.en    = 1'b0;
        bus.mode  = 1'b0;
        bus.sel   = 3'd0;
        bus.start = 1'b0;
        bus.dir   = 1'b0;
        #12;
        check("rst_y",    32'(bus.y),    32'd0);
        check("rst_idx",  32'(bus.idx),  32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("rel_en0_y", 32'(bus.y), 32'd0);

        for (int i = 0; i < 10; i++) begin
            bus.en   = vecs[i].en;
            bus.sel  = vecs[i].sel;
            bus.mode = 1'b0;
            tick();
            check($sformatf("direct%0d_y", i),   32'(bus.y),   32'(vecs[i].exp_y));
            check($sformatf("direct%0d_idx", i), 32'(bus.idx), 32'(vecs[i].exp_idx));
        end

        // Asynchronous reset while outputs are active.
        bus.en  = 1'b1;
        bus.sel = 3'd3;
        tick();
        check("pre_rst_y", 32'(bus.y), 32'h08);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_y",   32'(bus.y),   32'd0);
        check("async_rst_idx", 32'(bus.idx), 32'd0);
        bus.en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_en0_y", 32'(bus.y), 32'd0);

`ifdef DECODER_SCAN_EN
        // start with mode = 0 is a plain direct decode.
        bus.en    = 1'b1;
        bus.mode  = 1'b0;
        bus.sel   = 3'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("m0_start_y",    32'(bus.y),    32'h20);
        check("m0_start_busy", 32'(bus.busy), 32'd0);

        // start with en = 0 is ignored.
        bus.en    = 1'b0;
        bus.mode  = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("en0_start_busy", 32'(bus.busy), 32'd0);
        check("en0_start_y",    32'(bus.y),    32'd0);

        run_scan(3'd6, 1'b0, -1, "up");
        bus.en = 1'b1;
        tick();
        check("up_done_one_cycle", 32'(bus.done), 32'd0);
        check("up_idle_y",         32'(bus.y),    32'd0);

        run_scan(3'd1, 1'b1, -1, "down");
        // Back-to-back launch in the done cycle, with a stray start mid-scan.
        run_scan(3'd2, 1'b0, 3, "b2b_ign");

        // Abort: drop en on the 5th scan cycle.
        bus.mode  = 1'b1;
        bus.sel   = 3'd0;
        bus.dir   = 1'b0;
        bus.en    = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("abort_pre_y", 32'(bus.y), 32'(1 << (k / DW)));
            if (k == 4) bus.en = 1'b0;
            tick();
        end
        check("abort_y",    32'(bus.y),    32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_idx",  32'(bus.idx),  32'd2);
        tick();
        check("abort_done_late", 32'(bus.done), 32'd0);

        // Asynchronous reset in the middle of a scan.
        bus.en    = 1'b1;
        bus.sel   = 3'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("midscan_busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midscan_rst_y",    32'(bus.y),    32'd0);
        check("midscan_rst_busy", 32'(bus.busy), 32'd0);
        check("midscan_rst_idx",  32'(bus.idx),  32'd0);
        bus.en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("midscan_rel_y",    32'(bus.y),    32'd0);
        check("midscan_rel_busy", 32'(bus.busy), 32'd0);
`else
        // Pure decoder: scan controls have no effect.
        bus.en    = 1'b1;
        bus.mode  = 1'b1;
        bus.sel   = 3'd4;
        bus.dir   = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("noscan_busy", 32'(bus.busy), 32'd0);
        check("noscan_done", 32'(bus.done), 32'd0);
        check("noscan_y",    32'(bus.y),    32'h10);
        for (int k = 0; k < 4; k++) begin
            bus.sel = 3'(7 - k);
            tick();
            check("noscan_track_y",    32'(bus.y),    32'(1 << (7 - k)));
            check("noscan_track_busy", 32'(bus.busy), 32'd0);
            check("noscan_track_done", 32'(bus.done), 32'd0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
